// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared types and constants for the physical-memory responder slice.
//   state_t : responder FSM states
//   op_t    : operation latched at request acceptance
//   LINE_BITS / ADDR_BITS / OFFSET_BITS : line protocol geometry
// ---------------------------------------------------------------------------
package mem_pkg;

   localparam int unsigned LINE_BITS   = 128;
   localparam int unsigned ADDR_BITS   = 16;
   localparam int unsigned OFFSET_BITS = 4;

   typedef enum logic [1:0] {
      st_idle,
      st_busy,
      st_resp,
      st_guard
   } state_t;

   typedef enum logic {
      op_read,
      op_write
   } op_t;

endpackage

// File: rtl/mem_line_array.sv
// ---------------------------------------------------------------------------
// mem_line_array
// Synchronous single-port line RAM, 2^INDEX_BITS lines of LINE_BITS each.
// Read data is registered and refreshed on every clock edge from the
// presented index (read-before-write on a same-index write). The storage
// has no reset.
//   clk   : clock, rising edge
//   we    : write enable
//   index : line index
//   wdata : line to write
//   rdata : registered line read at index
// ---------------------------------------------------------------------------
module mem_line_array
   import mem_pkg::*;
#(
   parameter int unsigned INDEX_BITS = 12
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [INDEX_BITS-1:0] index,
   input  logic [LINE_BITS-1:0]  wdata,
   output logic [LINE_BITS-1:0]  rdata
);

   logic [LINE_BITS-1:0] lines [2**INDEX_BITS];

   always_ff @(posedge clk) begin
      if (we) begin
         lines[index] <= wdata;
      end
      rdata <= lines[index];
   end

endmodule

// File: rtl/phys_mem_responder.sv
// ---------------------------------------------------------------------------
// phys_mem_responder
// Responder end of the cache-to-physical-memory line protocol. Accepts one
// line read or write, answers it after a fixed latency with a one-cycle
// mem_resp pulse, then spends one guard cycle ignoring requests so that a
// requester still holding read/write in the resp cycle is not re-accepted.
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset (storage is not cleared)
//   mem_address : byte address of the line (bits [3:0] ignored)
//   mem_rdata   : read line, valid from the resp cycle, held until next read
//   mem_wdata   : write line
//   mem_read    : read request, level, held until resp
//   mem_write   : write request, level, held until resp (read wins if both)
//   mem_resp    : completion pulse, one cycle
// ---------------------------------------------------------------------------
module phys_mem_responder
   import mem_pkg::*;
#(
   parameter int unsigned READ_LATENCY  = 10,
   parameter int unsigned WRITE_LATENCY = 10,
   parameter int unsigned INDEX_BITS    = 12
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [ADDR_BITS-1:0] mem_address,
   output logic [LINE_BITS-1:0] mem_rdata,
   input  logic [LINE_BITS-1:0] mem_wdata,
   input  logic                 mem_read,
   input  logic                 mem_write,
   output logic                 mem_resp
);

   generate
      if (READ_LATENCY < 1 || READ_LATENCY > 255) begin : g_bad_rd_lat
         $error("READ_LATENCY must be in 1..255");
      end
      if (WRITE_LATENCY < 1 || WRITE_LATENCY > 255) begin : g_bad_wr_lat
         $error("WRITE_LATENCY must be in 1..255");
      end
      if (INDEX_BITS < 1 || INDEX_BITS > ADDR_BITS - OFFSET_BITS) begin : g_bad_index
         $error("INDEX_BITS must be in 1..12");
      end
   endgenerate

   localparam logic [7:0] RD_LOAD = 8'(READ_LATENCY - 1);
   localparam logic [7:0] WR_LOAD = 8'(WRITE_LATENCY - 1);

   state_t                state;
   op_t                   op;
   logic [7:0]            count;
   logic [INDEX_BITS-1:0] index_q;
   logic [LINE_BITS-1:0]  wdata_q;

   logic [INDEX_BITS-1:0] in_index;
   logic [INDEX_BITS-1:0] ram_index;
   logic                  ram_we;
   logic [LINE_BITS-1:0]  ram_rdata;

   // Offset and aliased upper address bits are intentionally unused.
   logic                  unused_addr_bits;

   assign unused_addr_bits = ^mem_address;
   assign in_index         = mem_address[OFFSET_BITS +: INDEX_BITS];

   // While idle the RAM is addressed straight from the request so the line
   // is already registered at the acceptance edge; this lets a latency of 1
   // complete a read with no extra RAM cycle. During BUSY the captured index
   // is used and the array cannot change under a pending read.
   assign ram_index = (state == st_idle) ? in_index : index_q;
   assign ram_we    = (state == st_busy) && (count == '0) && (op == op_write);

   mem_line_array #(
      .INDEX_BITS (INDEX_BITS)
   ) u_array (
      .clk   (clk),
      .we    (ram_we),
      .index (ram_index),
      .wdata (wdata_q),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= st_idle;
         op        <= op_read;
         count     <= '0;
         index_q   <= '0;
         wdata_q   <= '0;
         mem_resp  <= 1'b0;
         mem_rdata <= '0;
      end else begin
         case (state)
            st_idle: begin
               mem_resp <= 1'b0;
               if (mem_read) begin
                  index_q <= in_index;
                  count   <= RD_LOAD;
                  op      <= op_read;
                  state   <= st_busy;
               end else if (mem_write) begin
                  index_q <= in_index;
                  wdata_q <= mem_wdata;
                  count   <= WR_LOAD;
                  op      <= op_write;
                  state   <= st_busy;
               end
            end
            st_busy: begin
               if (count == '0) begin
                  // The write itself is committed by ram_we on this edge.
                  if (op == op_read) begin
                     mem_rdata <= ram_rdata;
                  end
                  mem_resp <= 1'b1;
                  state    <= st_resp;
               end else begin
                  count <= count - 8'd1;
               end
            end
            st_resp: begin
               mem_resp <= 1'b0;
               state    <= st_guard;
            end
            st_guard: begin
               state <= st_idle;
            end
            default: begin
               mem_resp <= 1'b0;
               state    <= st_idle;
            end
         endcase
      end
   end

endmodule
